// File: rtl/ex_advint_pkg.sv
// Shared codes and FSM encoding for the Raisin64 multi-cycle advanced integer unit.
package ex_advint_pkg;

    localparam logic [2:0] UNIT_MUL = 3'b000;
    localparam logic [2:0] UNIT_DIV = 3'b001;

    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_SS = 2'b01;
    localparam logic [1:0] MUL_SU = 2'b10;

    localparam int DIV_SIGNED = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/ex_advint_seq_core.sv
// Radix-2 iterative engine: shift-add multiply or restoring divide on magnitudes.
// The accumulator ends as {high, low} product or {remainder, quotient}.
module ex_advint_seq_core #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic            done,
    output logic [XLEN-1:0] res_lo,
    output logic [XLEN-1:0] res_hi
);
    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   addend;
    logic              div_q;
    logic              run;
    logic [CW-1:0]     cnt;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     sh;
    logic [XLEN:0]     diff;

    always_comb begin
        sum = {1'b0, acc[2*XLEN-1:XLEN]}
            + (acc[0] ? {1'b0, addend} : {(XLEN+1){1'b0}});
        sh = acc[2*XLEN-1:XLEN-1];
        diff = sh - {1'b0, addend};
        acc_next = {sum, acc[XLEN-1:1]};
        if (div_q) begin
            // Borrow out of the trial subtract means the divisor did not fit.
            if (!diff[XLEN]) begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            addend <= '0;
            div_q  <= 1'b0;
            run    <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            addend <= is_div ? b_mag : a_mag;
            div_q  <= is_div;
            run    <= 1'b1;
            cnt    <= CW'(XLEN - 1);
        end else if (run) begin
            acc <= acc_next;
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done   = run & (cnt == '0);
    assign res_lo = acc[XLEN-1:0];
    assign res_hi = acc[2*XLEN-1:XLEN];

endmodule

// File: rtl/ex_advint_mc.sv
// Multi-cycle MUL/DIV unit with busy/stall handshake and dual-destination commit.
// Optional EX_ADVINT_EARLY_OUT_EN: zero MUL operand or zero divisor skips iteration.
module ex_advint_mc
    import ex_advint_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RN_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            ex_enable,
    output logic            ex_busy,
    input  logic [RN_W-1:0] rd_in_rn,
    input  logic [RN_W-1:0] rd2_in_rn,
    input  logic [2:0]      unit,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] out,
    output logic [XLEN-1:0] out2,
    output logic [RN_W-1:0] rd_out_rn,
    output logic [RN_W-1:0] rd2_out_rn,
    output logic            valid,
    input  logic            stall
);
    state_t state;
    state_t next_state;

    logic            accept;
    logic            is_mul_in;
    logic            is_div_in;
    logic            is_nop_in;
    logic            a_sgn;
    logic            b_sgn;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            skip;
    logic            core_start;
    logic            core_done;
    logic [XLEN-1:0] core_lo;
    logic [XLEN-1:0] core_hi;

    logic            is_div_q;
    logic            zero_res_q;
    logic            div_zero_q;
    logic            neg_lo_q;
    logic            neg_hi_q;
    logic [XLEN-1:0] a_raw_q;
    logic [RN_W-1:0] rd_q;
    logic [RN_W-1:0] rd2_q;
    logic            fix_ph;
    logic [XLEN-1:0] fix_lo;
    logic [XLEN-1:0] fix_hi;
    logic [2*XLEN-1:0] prod_neg;

    assign ex_busy = (state != IDLE) | stall;
    assign accept  = ex_enable & ~ex_busy;

    assign is_mul_in = (unit == UNIT_MUL);
    assign is_div_in = (unit == UNIT_DIV);
    assign is_nop_in = ~is_mul_in & ~is_div_in;

    assign a_sgn = is_div_in ? op[DIV_SIGNED] : (op == MUL_SS) | (op == MUL_SU);
    assign b_sgn = is_div_in ? op[DIV_SIGNED] : (op == MUL_SS);
    assign neg_a = a_sgn & in1[XLEN-1];
    assign neg_b = b_sgn & in2[XLEN-1];
    assign a_mag = neg_a ? -in1 : in1;
    assign b_mag = neg_b ? -in2 : in2;

`ifdef EX_ADVINT_EARLY_OUT_EN
    assign skip = (is_mul_in & ((in1 == '0) | (in2 == '0)))
                | (is_div_in & (in2 == '0));
`else
    assign skip = 1'b0;
`endif

    assign core_start = accept & ~is_nop_in & ~skip;

    ex_advint_seq_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (core_start),
        .is_div (is_div_in),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .done   (core_done),
        .res_lo (core_lo),
        .res_hi (core_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (is_nop_in | skip) ? FIX : CALC;
                end
            end
            CALC: begin
                if (core_done) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                if (fix_ph) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!stall) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign prod_neg = -{core_hi, core_lo};

    // FIX spends one cycle on the wide negate and one on the output load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q   <= 1'b0;
            zero_res_q <= 1'b0;
            div_zero_q <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            a_raw_q    <= '0;
            rd_q       <= '0;
            rd2_q      <= '0;
            fix_ph     <= 1'b0;
            fix_lo     <= '0;
            fix_hi     <= '0;
            out        <= '0;
            out2       <= '0;
            rd_out_rn  <= '0;
            rd2_out_rn <= '0;
            valid      <= 1'b0;
        end else begin
            fix_ph <= (state == FIX) & ~fix_ph;
            if (accept) begin
                is_div_q   <= is_div_in;
                zero_res_q <= is_nop_in | (is_mul_in & skip);
                div_zero_q <= is_div_in & (in2 == '0);
                neg_lo_q   <= neg_a ^ neg_b;
                neg_hi_q   <= is_div_in ? neg_a : (neg_a ^ neg_b);
                a_raw_q    <= in1;
                rd_q       <= rd_in_rn;
                rd2_q      <= rd2_in_rn;
            end
            if (state == FIX && !fix_ph) begin
                if (is_div_q) begin
                    fix_lo <= neg_lo_q ? -core_lo : core_lo;
                    fix_hi <= neg_hi_q ? -core_hi : core_hi;
                end else begin
                    fix_lo <= neg_lo_q ? prod_neg[XLEN-1:0] : core_lo;
                    fix_hi <= neg_lo_q ? prod_neg[2*XLEN-1:XLEN] : core_hi;
                end
            end
            if (state == FIX && fix_ph) begin
                if (zero_res_q) begin
                    out  <= '0;
                    out2 <= '0;
                end else if (div_zero_q) begin
                    out  <= '1;
                    out2 <= a_raw_q;
                end else begin
                    out  <= fix_lo;
                    out2 <= fix_hi;
                end
                rd_out_rn  <= rd_q;
                rd2_out_rn <= rd2_q;
                valid      <= 1'b1;
            end else if (state == DONE && !stall) begin
                valid <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && ex_enable && ex_busy) begin
            $warning("ex_advint_mc: dispatch while busy dropped");
        end
    end
`endif

endmodule

// File: tb/tb_ex_advint_mc.sv
// Self-checking bench for ex_advint_mc against an arithmetic reference model.
module tb_ex_advint_mc;
    localparam int XLEN = 64;
    localparam int RN_W = 6;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] in1 = '0;
    logic [XLEN-1:0] in2 = '0;
    logic            ex_enable = 1'b0;
    logic            ex_busy;
    logic [RN_W-1:0] rd_in_rn = '0;
    logic [RN_W-1:0] rd2_in_rn = '0;
    logic [2:0]      unit = '0;
    logic [1:0]      op = '0;
    logic [XLEN-1:0] out;
    logic [XLEN-1:0] out2;
    logic [RN_W-1:0] rd_out_rn;
    logic [RN_W-1:0] rd2_out_rn;
    logic            valid;
    logic            stall = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_advint_mc #(.XLEN(XLEN), .RN_W(RN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in1        (in1),
        .in2        (in2),
        .ex_enable  (ex_enable),
        .ex_busy    (ex_busy),
        .rd_in_rn   (rd_in_rn),
        .rd2_in_rn  (rd2_in_rn),
        .unit       (unit),
        .op         (op),
        .out        (out),
        .out2       (out2),
        .rd_out_rn  (rd_out_rn),
        .rd2_out_rn (rd2_out_rn),
        .valid      (valid),
        .stall      (stall)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {out2, out} from the arithmetic definition of each operation.
    function automatic logic [127:0] model(input logic [2:0] u, input logic [1:0] o,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ae;
        logic [127:0] be;
        logic [63:0]  q;
        logic [63:0]  r;
        if (u == 3'b000) begin
            ae = (o == 2'b01 || o == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
            be = (o == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
            return ae * be;
        end
        if (u == 3'b001) begin
            if (b == 0) return {a, ONES};
            if (o[0]) begin
                if (a == MIN && b == ONES) return {64'b0, MIN};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            return {r, q};
        end
        return '0;
    endfunction

    function automatic int lat_of(input logic [2:0] u, input logic [63:0] a,
                                  input logic [63:0] b);
        if (u != 3'b000 && u != 3'b001) return 2;
`ifdef EX_ADVINT_EARLY_OUT_EN
        if (u == 3'b000 && (a == 0 || b == 0)) return 2;
        if (u == 3'b001 && b == 0) return 2;
`endif
        return XLEN + 2;
    endfunction

    function automatic logic [63:0] rand_opnd();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return MIN;
            2: return ONES;
            3: return 64'($urandom_range(0, 20));
            4: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called on a negedge with the unit idle; returns on a negedge.
    task automatic do_op(input string tag, input logic [2:0] u, input logic [1:0] o,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] exp, input bit hold);
        logic [RN_W-1:0] r1;
        logic [RN_W-1:0] r2;
        logic [63:0]     o1;
        logic [63:0]     o2;
        int n;
        bit busy_ok;
        bit hold_ok;
        r1 = RN_W'($urandom);
        r2 = RN_W'($urandom);
        chk({tag, " idle"}, ex_busy, 0);
        unit = u;
        op = o;
        in1 = a;
        in2 = b;
        rd_in_rn = r1;
        rd2_in_rn = r2;
        ex_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ex_enable = 1'b0;
        in1 = {$urandom, $urandom};
        in2 = {$urandom, $urandom};
        rd_in_rn = RN_W'($urandom);
        if (hold) stall = 1'b1;
        n = 0;
        busy_ok = 1'b1;
        while (valid !== 1'b1 && n < 300) begin
            if (ex_busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, lat_of(u, a, b));
        chk({tag, " busy"}, busy_ok, 1);
        chk({tag, " out"}, out, exp[63:0]);
        chk({tag, " out2"}, out2, exp[127:64]);
        chk({tag, " rd"}, rd_out_rn, r1);
        chk({tag, " rd2"}, rd2_out_rn, r2);
        if (hold) begin
            o1 = out;
            o2 = out2;
            hold_ok = 1'b1;
            for (int i = 0; i < 5; i++) begin
                ex_enable = i[0];
                unit = 3'b000;
                in1 = 64'd3;
                in2 = 64'd3;
                @(negedge clk);
                if (valid !== 1'b1 || ex_busy !== 1'b1 || out !== o1 ||
                    out2 !== o2 || rd_out_rn !== r1 || rd2_out_rn !== r2)
                    hold_ok = 1'b0;
            end
            chk({tag, " hold"}, hold_ok, 1);
            ex_enable = 1'b0;
            stall = 1'b0;
        end
        @(negedge clk);
        chk({tag, " valid drop"}, valid, 0);
        chk({tag, " busy drop"}, ex_busy, 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] u, input logic [1:0] o,
                          input logic [63:0] a, input logic [63:0] b);
        do_op(tag, u, o, a, b, model(u, o, a, b), 1'b0);
    endtask

    initial begin
        logic [2:0]  ru;
        logic [63:0] ra;
        logic [63:0] rb;
        bit          quiet;

        #1;
        chk("reset out", out, 0);
        chk("reset out2", out2, 0);
        chk("reset rd", {rd_out_rn, rd2_out_rn}, 0);
        chk("reset valid", valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", ex_busy, 0);

        do_op("t1 mul uu", 3'b000, 2'b00, ONES, 64'd2, {64'd1, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b0);
        do_op("t2 mul ss", 3'b000, 2'b01, -64'd3, 64'd5, {ONES, 64'hFFFF_FFFF_FFFF_FFF1}, 1'b0);
        do_op("t2 mul su", 3'b000, 2'b10, ONES, 64'd2, {ONES, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b0);
        do_op("t3 div s", 3'b001, 2'b01, -64'd7, 64'd2, {ONES, 64'hFFFF_FFFF_FFFF_FFFD}, 1'b0);
        do_op("t3 div ovf", 3'b001, 2'b01, MIN, ONES, {64'd0, MIN}, 1'b0);
        do_op("t4 div0 s", 3'b001, 2'b01, 64'h1234, 64'd0, {64'h1234, ONES}, 1'b0);
        do_op("t4 div0 u", 3'b001, 2'b00, 64'h1234, 64'd0, {64'h1234, ONES}, 1'b0);
        do_op("mul zero", 3'b000, 2'b01, 64'd0, -64'd9, 128'd0, 1'b0);
        do_op("mul op11", 3'b000, 2'b11, ONES, ONES, {64'hFFFF_FFFF_FFFF_FFFE, 64'd1}, 1'b0);
        do_op("nop", 3'b101, 2'b01, 64'd77, 64'd3, 128'd0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ru = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 7))
                                             : 3'($urandom_range(0, 1));
            ra = rand_opnd();
            rb = rand_opnd();
            run_op($sformatf("rand%0d", i), ru, 2'($urandom), ra, rb);
        end

        ra = {$urandom, $urandom};
        rb = 64'($urandom_range(1, 1000));
        do_op("t5 stall", 3'b001, 2'b01, ra, rb, model(3'b001, 2'b01, ra, rb), 1'b1);
        run_op("t5 next", 3'b000, 2'b01, 64'd11, -64'd4);

        unit = 3'b001;
        op = 2'b01;
        in1 = {$urandom, $urandom};
        in2 = 64'd13;
        ex_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ex_enable = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6 rst out", out, 0);
        chk("t6 rst out2", out2, 0);
        chk("t6 rst rd", {rd_out_rn, rd2_out_rn}, 0);
        chk("t6 rst valid", valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (valid !== 1'b0) quiet = 1'b0;
        end
        chk("t6 no valid", quiet, 1);
        do_op("t6 mul", 3'b000, 2'b00, 64'd6, 64'd7, {64'd0, 64'd42}, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
